// File: rtl/control_suma_if.sv
// rtl/control_suma_if.sv - key/adder/display bundle for the addition sequencer
//
// Signals:
//   key_valid    1  one-cycle key strobe
//   key_code     4  0-9 digit, A plus, B equal, C clear, D-F ignored
//   resultado_in 13 adder result
//   num1, num2   12 operands to the adder
//   suma_btn     1  one-cycle start pulse to the adder
//   display_val  13 value for the display path
//   estado       2  controller state
//   busy         1  high while the sum is settling
// Modports: master = keypad/adder side, slave = controller.
interface control_suma_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [12:0] resultado_in;
    logic [11:0] num1;
    logic [11:0] num2;
    logic        suma_btn;
    logic [12:0] display_val;
    logic [1:0]  estado;
    logic        busy;

    modport master (
        output key_valid, key_code, resultado_in,
        input  num1, num2, suma_btn, display_val, estado, busy
    );

    modport slave (
        input  key_valid, key_code, resultado_in,
        output num1, num2, suma_btn, display_val, estado, busy
    );
endinterface

// File: rtl/control_suma.sv
// rtl/control_suma.sv - keypad-driven sequencer for the 12-bit decimal adder
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  control_suma_if.slave: keys and adder result in; operands,
//        start pulse, display value, state and busy out (all registered)
module control_suma #(
    parameter int MAX_DIG  = 3,
    parameter int WAIT_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    control_suma_if.slave        bus
);
    typedef enum logic [1:0] {
        ENTRA_A = 2'd0,
        ENTRA_B = 2'd1,
        CALC    = 2'd2,
        MUESTRA = 2'd3
    } state_t;

    localparam int CW = (MAX_DIG < 2) ? 1 : $clog2(MAX_DIG + 1);
    localparam int WW = (WAIT_CYC < 2) ? 1 : $clog2(WAIT_CYC + 1);

    state_t         r_state, w_state;
    logic [11:0]    r_num1, w_num1;
    logic [11:0]    r_num2, w_num2;
    logic [12:0]    r_disp, w_disp;
    logic           r_btn, w_btn;
    logic           r_busy, w_busy;
    logic [CW-1:0]  r_cnt, w_cnt;
    logic [WW-1:0]  r_wait, w_wait;

    logic           w_digit, w_plus, w_equal, w_clear, w_can_append;
    logic [15:0]    w_app1, w_app2;

    assign w_digit      = bus.key_valid && (bus.key_code <= 4'd9);
    assign w_plus       = bus.key_valid && (bus.key_code == 4'hA);
    assign w_equal      = bus.key_valid && (bus.key_code == 4'hB);
    assign w_clear      = bus.key_valid && (bus.key_code == 4'hC);
    assign w_can_append = (r_cnt < CW'(MAX_DIG));

    // operand*10 + digit, widened so the multiply cannot wrap before truncation
    assign w_app1 = {4'd0, r_num1} * 16'd10 + {12'd0, bus.key_code};
    assign w_app2 = {4'd0, r_num2} * 16'd10 + {12'd0, bus.key_code};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ENTRA_A;
            r_num1  <= '0;
            r_num2  <= '0;
            r_disp  <= '0;
            r_btn   <= 1'b0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_state;
            r_num1  <= w_num1;
            r_num2  <= w_num2;
            r_disp  <= w_disp;
            r_btn   <= w_btn;
            r_busy  <= w_busy;
            r_cnt   <= w_cnt;
            r_wait  <= w_wait;
        end
    end

    always_comb begin
        w_state = r_state;
        w_num1  = r_num1;
        w_num2  = r_num2;
        w_disp  = r_disp;
        w_btn   = 1'b0;
        w_cnt   = r_cnt;
        w_wait  = r_wait;

        case (r_state)
            ENTRA_A: begin
                if (w_digit && w_can_append) begin
                    w_num1 = w_app1[11:0];
                    w_cnt  = r_cnt + CW'(1);
                end else if (w_plus && (r_cnt != '0)) begin
                    w_state = ENTRA_B;
                    w_cnt   = '0;
                    w_num2  = '0;
                end
            end
            ENTRA_B: begin
                if (w_digit && w_can_append) begin
                    w_num2 = w_app2[11:0];
                    w_cnt  = r_cnt + CW'(1);
                end else if (w_equal && (r_cnt != '0)) begin
                    w_state = CALC;
                    w_btn   = 1'b1;
                    w_wait  = '0;
                end
            end
            CALC: begin
                // r_wait counts CALC edges after the pulse; capture on the last
                if (r_wait == WW'(WAIT_CYC)) begin
                    w_disp  = bus.resultado_in;
                    w_state = MUESTRA;
                end else begin
                    w_wait = r_wait + WW'(1);
                end
            end
            MUESTRA: begin
                if (w_digit) begin
                    w_num1  = {8'd0, bus.key_code};
                    w_num2  = '0;
                    w_cnt   = CW'(1);
                    w_state = ENTRA_A;
                end else if (w_plus) begin
                    // previous result becomes operand A, saturated to 12 bits
                    w_num1  = r_disp[12] ? 12'hFFF : r_disp[11:0];
                    w_num2  = '0;
                    w_cnt   = '0;
                    w_state = ENTRA_B;
                end
            end
            default: w_state = ENTRA_A;
        endcase

        if (w_clear) begin
            w_state = ENTRA_A;
            w_num1  = '0;
            w_num2  = '0;
            w_disp  = '0;
            w_btn   = 1'b0;
            w_cnt   = '0;
            w_wait  = '0;
        end

        // entry states mirror the operand being typed
        if (w_state == ENTRA_A) begin
            w_disp = {1'b0, w_num1};
        end else if (w_state == ENTRA_B) begin
            w_disp = {1'b0, w_num2};
        end

        w_busy = (w_state == CALC);
    end

    assign bus.num1        = r_num1;
    assign bus.num2        = r_num2;
    assign bus.suma_btn    = r_btn;
    assign bus.display_val = r_disp;
    assign bus.estado      = r_state;
    assign bus.busy        = r_busy;
endmodule
